// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: turns PC fetch addresses into in-order {instr, addr} pairs for decode.
// Latency: addr accepted in cycle T -> instr_valid no earlier than cycle T+MEM_LAT+1.
// Backpressure: addr_ready drops when queued + in-flight fetches reach DEPTH; a return always has a slot.
//
// Ports:
//   clock, reset                    rising-edge clock, asynchronous active-high reset
//   addr_valid/addr/addr_ready      fetch request from the PC (valid/ready)
//   flush                           redirect; squashes queued and in-flight fetches
//   mem_rden/mem_addr/mem_q         synchronous imem read port, data MEM_LAT cycles after mem_rden
//   instr_valid/instr/instr_addr    show-ahead queue head towards decode
//   instr_ready                     decode consumes the head
//   busy                            queue or in-flight pipe non-empty
// Optional build macro FETCH_STATS_EN adds delivered_count (pops, wrapping) and
// dropped_count (entries squashed by flush, saturating).
module imem_fetch_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] addr,
  output logic              addr_ready,
  input  logic              flush,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  output logic              busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       delivered_count,
  output logic [15:0]       dropped_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] q_data_q [DEPTH];
  logic [DATA_W-1:0] q_data_d [DEPTH];
  logic [ADDR_W-1:0] q_addr_q [DEPTH];
  logic [ADDR_W-1:0] q_addr_d [DEPTH];
  logic [MEM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0] pipe_addr_q [MEM_LAT];
  logic [ADDR_W-1:0] pipe_addr_d [MEM_LAT];

  logic              run;
  logic              accept;
  logic              push;
  logic              pop;
  logic [LAT_W-1:0]  inflight;

  // Number of fetches issued to imem whose data has not yet reached the queue.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + LAT_W'(pipe_vld_q[i]);
    end
  end

  // Credits cover both queued and in-flight entries, so every return has a free slot.
  always_comb begin
    run         = (state_q == S_RUN);
    addr_ready  = run & ~flush & ((32'(count_q) + 32'(inflight)) < 32'(DEPTH));
    accept      = addr_valid & addr_ready;
    mem_rden    = accept;
    // Held at zero until the responder is running so every output reads 0 in reset.
    mem_addr    = run ? addr : '0;
    push        = pipe_vld_q[MEM_LAT-1] & ~flush;
    instr_valid = (count_q != '0) & ~flush;
    pop         = instr_valid & instr_ready;
    instr       = q_data_q[rd_ptr_q];
    instr_addr  = q_addr_q[rd_ptr_q];
    busy        = (count_q != '0) | (|pipe_vld_q);
  end

  always_comb begin
    state_d = S_RUN;

    // In-flight shift register: stage 0 loads on accept, last stage lines up with mem_q.
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = accept;
    pipe_addr_d[0] = addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    if (flush) begin
      pipe_vld_d = '0;
    end

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_data_d = q_data_q;
    q_addr_d = q_addr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        q_data_d[wr_ptr_q] = mem_q;
        q_addr_d[wr_ptr_q] = pipe_addr_q[MEM_LAT-1];
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_addr_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= q_data_d[i];
        q_addr_q[i] <= q_addr_d[i];
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] delivered_q, delivered_d;
  logic [15:0] dropped_q, dropped_d;
  logic [16:0] drop_sum;

  always_comb begin
    delivered_d = delivered_q + 32'(pop);
    // Squashed entries = everything outstanding at the flush edge.
    drop_sum    = {1'b0, dropped_q} + 17'(count_q) + 17'(inflight);
    dropped_d   = dropped_q;
    if (flush) begin
      dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delivered_q <= '0;
      dropped_q   <= '0;
    end else begin
      delivered_q <= delivered_d;
      dropped_q   <= dropped_d;
    end
  end

  assign delivered_count = delivered_q;
  assign dropped_count   = dropped_q;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: one instance with MEM_LAT=1 and one with MEM_LAT=3.
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
module tb_imem_fetch_responder;
  localparam int DEPTH = 4;
  localparam int LAT3  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- instance with MEM_LAT=1 ----------------
  logic        rst1 = 1'b1, av1 = 1'b0, fl1 = 1'b0, ir1 = 1'b0;
  logic [31:0] a1 = '0;
  logic        ar1, rden1, iv1, busy1;
  logic [31:0] maddr1, ins1, iaddr1;
  logic [31:0] mq1 = '0;
`ifdef FETCH_STATS_EN
  logic [31:0] dc1, dc3;
  logic [15:0] dr1, dr3;
`endif

  imem_fetch_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MEM_LAT(1)) dut1 (
    .clock(clock), .reset(rst1), .addr_valid(av1), .addr(a1), .addr_ready(ar1), .flush(fl1),
    .mem_rden(rden1), .mem_addr(maddr1), .mem_q(mq1), .instr_valid(iv1), .instr(ins1),
    .instr_addr(iaddr1), .instr_ready(ir1), .busy(busy1)
`ifdef FETCH_STATS_EN
    , .delivered_count(dc1), .dropped_count(dr1)
`endif
  );

  // imem model: requested word one cycle after the strobe, random junk otherwise.
  always @(posedge clock) mq1 <= rden1 ? imem_f(maddr1) : $urandom;

  // ---------------- instance with MEM_LAT=3 ----------------
  logic        rst3 = 1'b1, av3 = 1'b0, fl3 = 1'b0, ir3 = 1'b0;
  logic [31:0] a3 = '0;
  logic        ar3, rden3, iv3, busy3;
  logic [31:0] maddr3, ins3, iaddr3;
  logic [31:0] mq3 = '0, m3_s0 = '0, m3_s1 = '0;

  imem_fetch_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MEM_LAT(LAT3)) dut3 (
    .clock(clock), .reset(rst3), .addr_valid(av3), .addr(a3), .addr_ready(ar3), .flush(fl3),
    .mem_rden(rden3), .mem_addr(maddr3), .mem_q(mq3), .instr_valid(iv3), .instr(ins3),
    .instr_addr(iaddr3), .instr_ready(ir3), .busy(busy3)
`ifdef FETCH_STATS_EN
    , .delivered_count(dc3), .dropped_count(dr3)
`endif
  );

  always @(posedge clock) begin
    m3_s0 <= rden3 ? imem_f(maddr3) : $urandom;
    m3_s1 <= m3_s0;
    mq3   <= m3_s1;
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        rst, av;
    logic [31:0] a;
    logic        fl, ir;
    logic        e_ar, e_iv;
    logic [31:0] e_ia;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic av, input logic [31:0] a,
                              input logic fl, input logic ir, input logic e_ar,
                              input logic e_iv, input logic [31:0] e_ia, input logic e_busy);
    vec_t v;
    v.rst = rst; v.av = av; v.a = a; v.fl = fl; v.ir = ir;
    v.e_ar = e_ar; v.e_iv = e_iv; v.e_ia = e_ia; v.e_busy = e_busy;
    return v;
  endfunction

  typedef struct {
    logic [31:0] a;
    int          t;
  } ent_t;

  vec_t        tbl [12];
  logic [31:0] exp_q [$];
  ent_t        mdl [$];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : main
    int          acc;
    int          pops_total;
    logic [31:0] nxt;
    logic [31:0] e;
    logic        done_acc, seen;
    logic        run3;
    int          cyc3;
    logic        e_ar, e_iv;
`ifdef FETCH_STATS_EN
    logic [15:0] dr_before;
`endif

    //          rst   av    a       fl    ir    e_ar  e_iv  e_ia    e_busy
    tbl[0]  = mk(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1);
    tbl[10] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0);

    // Reset release, first fetch, pop, flush of a queued entry plus a returning one.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      rst1 = tbl[i].rst; av1 = tbl[i].av; a1 = tbl[i].a; fl1 = tbl[i].fl; ir1 = tbl[i].ir;
      #1;
      chk($sformatf("vec%0d_addr_ready", i), 64'(ar1), 64'(tbl[i].e_ar));
      chk($sformatf("vec%0d_mem_rden", i), 64'(rden1), 64'(tbl[i].e_ar & tbl[i].av));
      chk($sformatf("vec%0d_instr_valid", i), 64'(iv1), 64'(tbl[i].e_iv));
      chk($sformatf("vec%0d_busy", i), 64'(busy1), 64'(tbl[i].e_busy));
      if (tbl[i].e_iv) begin
        chk($sformatf("vec%0d_instr_addr", i), 64'(iaddr1), 64'(tbl[i].e_ia));
        chk($sformatf("vec%0d_instr", i), 64'(ins1), 64'(imem_f(tbl[i].e_ia)));
      end
      if (tbl[i].rst) begin
        chk("reset_instr", 64'(ins1), 64'h0);
        chk("reset_instr_addr", 64'(iaddr1), 64'h0);
        chk("reset_mem_addr", 64'(maddr1), 64'h0);
`ifdef FETCH_STATS_EN
        chk("reset_delivered", 64'(dc1), 64'h0);
        chk("reset_dropped", 64'(dr1), 64'h0);
`endif
      end
    end
    pops_total = 1;

    // Stream addresses with decode stalled: exactly DEPTH accepts.
    acc = 0;
    nxt = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      av1 = 1'b1; a1 = nxt; ir1 = 1'b0; fl1 = 1'b0;
      #1;
      if (ar1) begin
        exp_q.push_back(nxt);
        nxt = nxt + 32'h1;
        acc++;
      end
    end
    chk("t2_accepts", 64'(acc), 64'(DEPTH));
    chk("t2_ready_low_when_full", 64'(ar1), 64'h0);

    // Release decode: in-order drain, accepts resume, then steady one-in/one-out.
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      av1 = 1'b1; a1 = nxt; ir1 = 1'b1;
      #1;
      if (k >= 4) begin
        chk("t3_steady_valid", 64'(iv1), 64'h1);
        chk("t3_steady_ready", 64'(ar1), 64'h1);
      end
      if (iv1) begin
        if (exp_q.size() == 0) begin
          chk("t2_unexpected_pop", 64'(iaddr1), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("t2_order_addr", 64'(iaddr1), 64'(e));
          chk("t2_order_instr", 64'(ins1), 64'(imem_f(e)));
        end
        pops_total++;
      end
      if (ar1) begin
        exp_q.push_back(nxt);
        nxt = nxt + 32'h1;
        acc++;
      end
    end
    chk("t2_accepts_resumed", 64'(acc > 20), 64'h1);

    // Drain everything outstanding.
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      av1 = 1'b0; ir1 = 1'b1;
      #1;
      if (iv1) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("t3_drain_addr", 64'(iaddr1), 64'(e));
        end
        pops_total++;
      end
    end
    chk("t3_drained_busy", 64'(busy1), 64'h0);
    chk("t3_drained_all", 64'(exp_q.size()), 64'h0);
`ifdef FETCH_STATS_EN
    chk("t3_delivered", 64'(dc1), 64'(pops_total));
`endif

    // Flush with 3 queued + 1 in flight.
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      av1 = 1'b1; a1 = 32'h100 + 32'(k); ir1 = 1'b0;
      #1;
      chk("t4_accept", 64'(ar1), 64'h1);
    end
    @(negedge clock);
    av1 = 1'b0; fl1 = 1'b1;
    #1;
    chk("t4_flush_cycle_valid", 64'(iv1), 64'h0);
    chk("t4_flush_cycle_busy", 64'(busy1), 64'h1);
`ifdef FETCH_STATS_EN
    dr_before = dr1;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      fl1 = 1'b0; ir1 = 1'b1;
      #1;
      chk("t4_post_flush_valid", 64'(iv1), 64'h0);
      chk("t4_post_flush_busy", 64'(busy1), 64'h0);
    end
`ifdef FETCH_STATS_EN
    chk("t4_dropped", 64'(dr1 - dr_before), 64'h4);
`endif

    // Asynchronous reset between edges while entries are pending.
    @(negedge clock);
    av1 = 1'b1; a1 = 32'h200; ir1 = 1'b0;
    @(negedge clock);
    a1 = 32'h204;
    @(negedge clock);
    a1 = 32'h208;
    #1;
    chk("t5_pre_reset_valid", 64'(iv1), 64'h1);
    #1;
    rst1 = 1'b1;
    #1;
    chk("t5_rst_addr_ready", 64'(ar1), 64'h0);
    chk("t5_rst_instr_valid", 64'(iv1), 64'h0);
    chk("t5_rst_busy", 64'(busy1), 64'h0);
    chk("t5_rst_mem_rden", 64'(rden1), 64'h0);
    chk("t5_rst_mem_addr", 64'(maddr1), 64'h0);
    chk("t5_rst_instr", 64'(ins1), 64'h0);
    chk("t5_rst_instr_addr", 64'(iaddr1), 64'h0);
    @(negedge clock);
    rst1 = 1'b0; av1 = 1'b1; a1 = 32'h300; ir1 = 1'b1;
    done_acc = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      #1;
      if (ar1) done_acc = 1'b1;
      if (iv1) begin
        seen = 1'b1;
        chk("t5_first_addr", 64'(iaddr1), 64'h300);
      end
      @(negedge clock);
      if (done_acc) av1 = 1'b0;
    end
    chk("t5_first_seen", 64'(seen), 64'h1);
    av1 = 1'b0;

    // Randomised traffic on the MEM_LAT=3 instance against a credit/queue model.
    run3 = 1'b0;
    cyc3 = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      rst3 = 1'b0;
      av3  = ($urandom_range(0, 9) < 7);
      a3   = $urandom;
      if ((i >= 150 && i < 154) || (i >= 300 && i < 302))
        fl3 = 1'b1;
      else
        fl3 = ($urandom_range(0, 11) == 0);
      ir3  = (i >= 200 && i < 260) ? 1'b0 : ($urandom_range(0, 9) < 6);
      #1;
      e_ar = run3 && !fl3 && (mdl.size() < DEPTH);
      e_iv = !fl3 && (mdl.size() > 0) && (cyc3 >= mdl[0].t + LAT3 + 1);
      chk("rnd_addr_ready", 64'(ar3), 64'(e_ar));
      chk("rnd_mem_rden", 64'(rden3), 64'(e_ar && av3));
      chk("rnd_instr_valid", 64'(iv3), 64'(e_iv));
      chk("rnd_busy", 64'(busy3), 64'(mdl.size() > 0));
      if (e_ar && av3) chk("rnd_mem_addr", 64'(maddr3), 64'(a3));
      if (e_iv) begin
        chk("rnd_instr_addr", 64'(iaddr3), 64'(mdl[0].a));
        chk("rnd_instr", 64'(ins3), 64'(imem_f(mdl[0].a)));
      end
      if (fl3) begin
        mdl.delete();
      end else begin
        if (e_iv && ir3) mdl.delete(0);
        if (e_ar && av3) mdl.push_back('{a3, cyc3});
      end
      run3 = 1'b1;
      cyc3++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
